// File: rtl/translated_addressed_demux_register.sv
// Write-side address demux: claims writes in [BASE, BASE+COUNT), translates them to a
// 0-based index and stores the data in per-index registers with strobe and pending flags.
module translated_addressed_demux_register #(
  parameter int unsigned              WORD_WIDTH        = 36,
  parameter int unsigned              ADDR_WIDTH        = 10,
  parameter int unsigned              OUTPUT_COUNT      = 3,
  parameter int unsigned              OUTPUT_BASE_ADDR  = 5,
  parameter int unsigned              OUTPUT_ADDR_WIDTH = 2,
  parameter logic [WORD_WIDTH-1:0]    RESET_VALUE       = '0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               write_enable,
  input  logic [ADDR_WIDTH-1:0]              write_addr,
  input  logic [WORD_WIDTH-1:0]              write_data,
  input  logic [OUTPUT_COUNT-1:0]            ack,
  output logic [OUTPUT_COUNT*WORD_WIDTH-1:0] out,
  output logic [OUTPUT_COUNT-1:0]            out_wren,
  output logic [OUTPUT_COUNT-1:0]            out_pending,
  output logic                               write_hit
);

  // Range must fit inside the raw address space and the index must cover every register.
  if ((longint'(OUTPUT_BASE_ADDR) + longint'(OUTPUT_COUNT)) > (longint'(1) << ADDR_WIDTH)) begin : g_range_check
    $error("OUTPUT_BASE_ADDR + OUTPUT_COUNT exceeds the ADDR_WIDTH address space");
  end
  if ((longint'(1) << OUTPUT_ADDR_WIDTH) < longint'(OUTPUT_COUNT)) begin : g_index_check
    $error("OUTPUT_ADDR_WIDTH too narrow for OUTPUT_COUNT");
  end
  if (OUTPUT_COUNT < 1) begin : g_count_check
    $error("OUTPUT_COUNT must be at least 1");
  end

  // One extra bit so BASE+COUNT == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] BASE_W  = (ADDR_WIDTH+1)'(OUTPUT_BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] LIMIT_W = (ADDR_WIDTH+1)'(OUTPUT_BASE_ADDR + OUTPUT_COUNT);

  logic [WORD_WIDTH-1:0]        regs_q [OUTPUT_COUNT];
  logic [WORD_WIDTH-1:0]        regs_d [OUTPUT_COUNT];
  logic [OUTPUT_COUNT-1:0]      wren_q, wren_d;
  logic [OUTPUT_COUNT-1:0]      pending_q, pending_d;
  logic                         hit_q, hit_d;

  logic [ADDR_WIDTH:0]          addr_ext;
  logic                         hit;
  logic [OUTPUT_ADDR_WIDTH-1:0] index;

  always_comb begin
    addr_ext = {1'b0, write_addr};
    hit      = write_enable && (addr_ext >= BASE_W) && (addr_ext < LIMIT_W);
    index    = OUTPUT_ADDR_WIDTH'(write_addr - BASE_W[ADDR_WIDTH-1:0]);
  end

  always_comb begin
    regs_d    = regs_q;
    wren_d    = '0;
    pending_d = pending_q & ~ack;
    hit_d     = hit;
    // A write to an index overrides a same-cycle ack on that index.
    for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
      if (hit && (index == OUTPUT_ADDR_WIDTH'(i))) begin
        regs_d[i]    = write_data;
        wren_d[i]    = 1'b1;
        pending_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q    <= '{default: RESET_VALUE};
      wren_q    <= '0;
      pending_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      wren_q    <= wren_d;
      pending_q <= pending_d;
      hit_q     <= hit_d;
    end
  end

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
      out[i*WORD_WIDTH +: WORD_WIDTH] = regs_q[i];
    end
  end

  assign out_wren    = wren_q;
  assign out_pending = pending_q;
  assign write_hit   = hit_q;

endmodule

// File: tb/tb_translated_addressed_demux_register.sv
// Randomized, self-checking bench for translated_addressed_demux_register against an
// array-based model of the range-decode / pending-flag rules.
module tb_translated_addressed_demux_register;

  localparam int unsigned WW    = 36;
  localparam int unsigned AW    = 10;
  localparam int unsigned CNT   = 3;
  localparam int unsigned BASE  = 5;
  localparam int unsigned OAW   = 2;

  logic                clock;
  logic                reset_n;
  logic                write_enable;
  logic [AW-1:0]       write_addr;
  logic [WW-1:0]       write_data;
  logic [CNT-1:0]      ack;
  logic [CNT*WW-1:0]   out;
  logic [CNT-1:0]      out_wren;
  logic [CNT-1:0]      out_pending;
  logic                write_hit;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // Reference model state
  logic [WW-1:0]  m_reg [CNT];
  logic [CNT-1:0] m_pend;
  logic [CNT-1:0] m_wren;
  logic           m_hit;

  translated_addressed_demux_register #(
    .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .OUTPUT_COUNT(CNT),
    .OUTPUT_BASE_ADDR(BASE), .OUTPUT_ADDR_WIDTH(OAW), .RESET_VALUE('0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data), .ack(ack),
    .out(out), .out_wren(out_wren), .out_pending(out_pending), .write_hit(write_hit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [CNT*WW-1:0] exp_out();
    logic [CNT*WW-1:0] v;
    v = '0;
    for (int i = 0; i < CNT; i++) v[i*WW +: WW] = m_reg[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CNT; i++) m_reg[i] = '0;
    m_pend = '0;
    m_wren = '0;
    m_hit  = 1'b0;
  endtask

  // Drive one cycle of stimulus (called just after a falling edge), advance the model by the
  // spec's rules, and return at the next falling edge ready for sampling.
  task automatic step(input logic we, input int unsigned a, input logic [WW-1:0] d,
                      input logic [CNT-1:0] k);
    int unsigned idx;
    bit          claimed;
    write_enable = we;
    write_addr   = AW'(a);
    write_data   = d;
    ack          = k;
    claimed = we && (a >= BASE) && (a < BASE + CNT);
    m_pend  = m_pend & ~k;
    m_wren  = '0;
    m_hit   = claimed;
    if (claimed) begin
      idx         = a - BASE;
      m_reg[idx]  = d;
      m_wren[idx] = 1'b1;
      m_pend[idx] = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
    write_enable = 1'b0;
    ack          = '0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    write_enable = 1'b1;
    write_addr   = AW'(5);
    write_data   = WW'(36'h123);
    ack          = '0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({out, out_wren, out_pending, write_hit} !== '0) begin
        $display("FAIL reset_hold cyc%0d: out=%h wren=%b pend=%b hit=%b required all zero",
                 c, out, out_wren, out_pending, write_hit);
        fails++;
      end
    end
    write_enable = 1'b0;
    reset_n      = 1'b1;
    step(1'b0, 0, '0, '0);
    checks++;
    if ({out, out_wren, out_pending, write_hit} !== '0) begin
      $display("FAIL reset_release: out=%h wren=%b pend=%b hit=%b required all zero",
               out, out_wren, out_pending, write_hit);
      fails++;
    end
  endtask

  task automatic test_in_range();
    logic [CNT-1:0] exp_strobe [3] = '{3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, BASE + i, WW'(36'hA + i), '0);
      checks++;
      if (out_wren !== exp_strobe[i] || write_hit !== 1'b1) begin
        $display("FAIL in_range_strobe%0d: wren=%b hit=%b required wren=%b hit=1",
                 i, out_wren, write_hit, exp_strobe[i]);
        fails++;
      end
    end
    checks++;
    if (out !== {36'hC, 36'hB, 36'hA} || out_pending !== 3'b111 || out !== exp_out()) begin
      $display("FAIL in_range_data: out=%h pend=%b required out=%h pend=111",
               out, out_pending, {36'hC, 36'hB, 36'hA});
      fails++;
    end
  endtask

  task automatic test_boundary_miss();
    int unsigned addrs [3] = '{BASE - 1, BASE + CNT, BASE + 1};
    logic        ens   [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(ens[i], addrs[i], WW'(36'hFFF), '0);
      checks++;
      if (out !== exp_out() || out_wren !== '0 || write_hit !== 1'b0 || out_pending !== m_pend) begin
        $display("FAIL boundary_miss addr%0d en%0d: out=%h wren=%b hit=%b pend=%b required out=%h wren=000 hit=0 pend=%b",
                 addrs[i], ens[i], out, out_wren, write_hit, out_pending, exp_out(), m_pend);
        fails++;
      end
    end
  endtask

  task automatic test_ack_collision();
    step(1'b1, BASE + 1, WW'(36'h55), 3'b010);
    checks++;
    if (out_pending[1] !== 1'b1 || out[WW +: WW] !== WW'(36'h55)) begin
      $display("FAIL ack_collision: pend1=%b out1=%h required pend1=1 out1=55",
               out_pending[1], out[WW +: WW]);
      fails++;
    end
    step(1'b0, 0, '0, 3'b010);
    checks++;
    if (out_pending[1] !== 1'b0 || out_pending !== m_pend || out !== exp_out()) begin
      $display("FAIL ack_clear: pend=%b out=%h required pend=%b out=%h",
               out_pending, out, m_pend, exp_out());
      fails++;
    end
  endtask

  task automatic test_stale_ack();
    step(1'b0, 0, '0, 3'b111);
    checks++;
    if (out_pending !== 3'b000) begin
      $display("FAIL ack_all: pend=%b required 000", out_pending);
      fails++;
    end
    step(1'b0, 0, '0, 3'b111);
    checks++;
    if (out_pending !== 3'b000 || out !== exp_out() || out_wren !== '0) begin
      $display("FAIL stale_ack: pend=%b out=%h wren=%b required pend=000 out=%h wren=000",
               out_pending, out, out_wren, exp_out());
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, BASE + 2, WW'(36'h100 + i), '0);
      checks++;
      if (out_wren !== 3'b100 || out[2*WW +: WW] !== WW'(36'h100 + i) || write_hit !== 1'b1) begin
        $display("FAIL back_to_back%0d: wren=%b out2=%h hit=%b required wren=100 out2=%h hit=1",
                 i, out_wren, out[2*WW +: WW], write_hit, 36'h100 + i);
        fails++;
      end
    end
  endtask

  task automatic test_random();
    int unsigned a;
    for (int c = 0; c < 300; c++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << AW) - 1) : $urandom_range(0, BASE + CNT + 2);
      step(1'($urandom_range(0, 1)), a, {4'($urandom), 32'($urandom)}, CNT'($urandom));
      checks++;
      if (out !== exp_out() || out_wren !== m_wren || out_pending !== m_pend || write_hit !== m_hit) begin
        $display("FAIL random cyc%0d addr%0d: out=%h wren=%b pend=%b hit=%b required out=%h wren=%b pend=%b hit=%b",
                 c, a, out, out_wren, out_pending, write_hit, exp_out(), m_wren, m_pend, m_hit);
        fails++;
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, BASE + i, WW'(36'hA + i), '0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out, out_wren, out_pending, write_hit} !== '0) begin
      $display("FAIL async_reset: out=%h wren=%b pend=%b hit=%b required all zero before edge",
               out, out_wren, out_pending, write_hit);
      fails++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 0, '0, '0);
    checks++;
    if ({out, out_wren, out_pending, write_hit} !== '0) begin
      $display("FAIL async_release: out=%h wren=%b pend=%b hit=%b required all zero",
               out, out_wren, out_pending, write_hit);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_in_range();
    test_boundary_miss();
    test_ack_collision();
    test_stale_ack();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/translated_addressed_demux_register.md
Name: translated_addressed_demux_register

Overview:
- Write-side counterpart of the translated read mux: accepts raw memory writes, claims those whose address falls in a consecutive, non-power-of-2-aligned range, translates the address to a 0-based index, and stores the data in one of OUTPUT_COUNT memory-mapped registers.
- Sits between the core's write port and memory-mapped peripherals.
- Drives each register's value, a one-cycle write strobe, and a pending flag that the consumer clears by acknowledging.

Parameters:
- WORD_WIDTH, 36, data width of each register.
- ADDR_WIDTH, 10, raw write address width.
- OUTPUT_COUNT, 3, number of registers (>=1, need not be power of 2).
- OUTPUT_BASE_ADDR, 5, raw address of register 0.
- OUTPUT_ADDR_WIDTH, 2, translated index width; must satisfy 2**OUTPUT_ADDR_WIDTH >= OUTPUT_COUNT.
- RESET_VALUE, 0, WORD_WIDTH value loaded into every register on reset.

Ports:
- clock  input  1  sole clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write_enable  input  1  raw write request this cycle.
- write_addr  input  ADDR_WIDTH  raw write address.
- write_data  input  WORD_WIDTH  write data.
- ack  input  OUTPUT_COUNT  per-register consumer acknowledge; clears pending.
- out  output  OUTPUT_COUNT*WORD_WIDTH  register values; register i at bits [i*WORD_WIDTH +: WORD_WIDTH].
- out_wren  output  OUTPUT_COUNT  one-cycle strobe, bit i high the cycle after register i is written.
- out_pending  output  OUTPUT_COUNT  bit i set by a write to register i, held until acked.
- write_hit  output  1  registered; high the cycle after an accepted (in-range) write.

Behaviour:
- Reset: reset_n low forces the following asynchronously, and they hold while reset_n is low:
  - every register to RESET_VALUE;
  - out_wren, out_pending and write_hit to 0.
- Release is synchronous to the next clock edge.
- Range decode:
  - hit = write_enable AND (write_addr >= OUTPUT_BASE_ADDR) AND (write_addr < OUTPUT_BASE_ADDR + OUTPUT_COUNT).
  - Compare over the full ADDR_WIDTH, not truncated low bits.
  - index = write_addr - OUTPUT_BASE_ADDR, truncated to OUTPUT_ADDR_WIDTH.
- Miss: a write with hit=0 changes no register, strobe, pending bit or write_hit. It is silently ignored.
- Write latency (hit at edge N):
  - out[index] shows write_data from N+1.
  - out_wren[index] is high for exactly cycle N+1; all other strobe bits are 0.
  - write_hit is high for cycle N+1.
  - out_pending[index] is 1 from N+1.
- Back-to-back writes: one write is accepted per cycle, with no stall.
  - Consecutive writes to the same index give the last value and a strobe on each cycle.
  - Consecutive writes to different indices give strobes on successive cycles.
- Pending flag, per bit i, evaluated at each edge:
  - write to i: set to 1 (write wins over a simultaneous ack[i]);
  - else ack[i]=1: clear to 0;
  - else hold.
  - ack on a bit that is not pending has no effect.
- out is purely registered, with no combinational path from any input to any output.
- Register values hold indefinitely between writes. Acks never alter register data.
- Range edge handling, base+count wrap:
  - addresses OUTPUT_BASE_ADDR-1 and OUTPUT_BASE_ADDR+OUTPUT_COUNT are misses;
  - if OUTPUT_BASE_ADDR + OUTPUT_COUNT > 2**ADDR_WIDTH, elaboration must fail.
- Reset mid-operation: a write presented in the same cycle reset_n is asserted is discarded. No strobe or pending appears after release.

Test Plan:
- Reset values: hold reset_n=0 with write_enable=1, addr 5, data 0x123, then release → out all 0, out_wren=000, out_pending=000, write_hit=0 throughout reset and on the first post-release cycle.
- In-range writes: write addr 5 data 0xA, addr 6 data 0xB, addr 7 data 0xC on consecutive cycles → out_wren 001, 010, 100 on successive cycles; out = {0xC,0xB,0xA}; out_pending=111; write_hit high 3 cycles.
- Boundary misses: write addr 4 and addr 8 with data 0xFFF → out unchanged, out_wren=000, write_hit=0. Also write_enable=0 with addr 6 → no change.
- Ack vs write collision: with pending[1]=1, write addr 6 data 0x55 with ack=010 in the same cycle → pending[1] stays 1, out[1]=0x55. A following ack=010 with no write → pending[1]=0 next cycle.
- Stale ack: ack=111 with pending=000 → pending stays 000, out unchanged.
- Async reset mid-stream: after loading 0xA/0xB/0xC, pulse reset_n low between edges → out and pending zero immediately, before the next edge.
